// File: rtl/button_debounce_if.sv
// Button conditioning bundle between the debouncer and the buttons/LEDs peripheral.
// slave: debouncer side (takes raw pads and clear strobes, drives conditioned outputs).
// master: peripheral side (drives pads/clears, consumes levels, pulses, flags and irq).
interface button_debounce_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] buttons_i;
    logic [NUM_BUTTONS-1:0] event_clr_i;
    logic [NUM_BUTTONS-1:0] buttons_o;
    logic [NUM_BUTTONS-1:0] press_o;
    logic [NUM_BUTTONS-1:0] release_o;
    logic [NUM_BUTTONS-1:0] event_o;
    logic                   irq_o;

    modport master (
        output buttons_i,
        output event_clr_i,
        input  buttons_o,
        input  press_o,
        input  release_o,
        input  event_o,
        input  irq_o
    );

    modport slave (
        input  buttons_i,
        input  event_clr_i,
        output buttons_o,
        output press_o,
        output release_o,
        output event_o,
        output irq_o
    );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus per-channel stability counter for raw button pads.
// Latency: a held raw level reaches buttons_o DEBOUNCE_CYCLES+2 edges after it is first sampled.
// No backpressure; event_o is sticky until event_clr_i. BUTTON_DEBOUNCE_RELEASE_EVENT_EN also sets event_o on release.
module button_debounce #(
    parameter int NUM_BUTTONS     = 3,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    button_debounce_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0]                sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0]                sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0]                stable_q, stable_d;
    logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_BUTTONS-1:0]                press_q, press_d;
    logic [NUM_BUTTONS-1:0]                release_q, release_d;
    logic [NUM_BUTTONS-1:0]                event_q, event_d;
    logic                                  irq_q, irq_d;
    logic [NUM_BUTTONS-1:0]                accept;
    logic [NUM_BUTTONS-1:0]                event_set;

    // Next-state: synchronizer shift, stability counting, edge pulses and sticky flags.
    always_comb begin
        sync1_d   = bus.buttons_i;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        accept    = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Held long enough: adopt the synchronized level.
                accept[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
        stable_d  = stable_q ^ accept;
        press_d   = accept & sync2_q;
        release_d = accept & ~sync2_q;
        // A flag is set both on the edge that raises the pulse and while the pulse
        // is visible, so a clear landing in the pulse cycle loses to the set.
`ifdef BUTTON_DEBOUNCE_RELEASE_EVENT_EN
        event_set = press_d | press_q | release_d | release_q;
`else
        event_set = press_d | press_q;
`endif
        event_d   = (event_q & ~bus.event_clr_i) | event_set;
        irq_d     = |event_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            event_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.buttons_o = stable_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.event_o   = event_q;
    assign bus.irq_o     = irq_q;
endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with DEBOUNCE_CYCLES=4: directed scenarios plus random stimulus,
// every cycle compared against a sample-history reference model.
// Build with BUTTON_DEBOUNCE_RELEASE_EVENT_EN to cover release-set event flags.
module tb_button_debounce;
    localparam int NB = 3;
    localparam int DC = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    button_debounce_if #(.NUM_BUTTONS(NB)) bus ();

    button_debounce #(
        .NUM_BUTTONS    (NB),
        .CNT_WIDTH      (16),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Reference model: a level is accepted once the DC raw samples taken 2..DC+1
    // edges ago all differ from the current debounced level.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_btn, m_press, m_rel, m_evt;
    logic          m_irq;

    always @(posedge wb_clk_i) begin
        logic [NB-1:0] acc, nb, np, nr, ne, setv;
        if (wb_rst_i) begin
            hist.delete();
            hist.push_back('0);
            m_btn = '0; m_press = '0; m_rel = '0; m_evt = '0; m_irq = 1'b0;
        end else begin
            hist.push_back(bus.buttons_i);
            if (hist.size() > DC + 2) void'(hist.pop_front());
            acc = '0;
            if (hist.size() == DC + 2) begin
                for (int ch = 0; ch < NB; ch++) begin
                    acc[ch] = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (hist[k][ch] == m_btn[ch]) acc[ch] = 1'b0;
                end
            end
            nb = m_btn ^ acc;
            np = acc & nb;
            nr = acc & ~nb;
`ifdef BUTTON_DEBOUNCE_RELEASE_EVENT_EN
            setv = np | m_press | nr | m_rel;
`else
            setv = np | m_press;
`endif
            ne = (m_evt & ~bus.event_clr_i) | setv;
            m_irq   = |m_evt;
            m_btn   = nb;
            m_press = np;
            m_rel   = nr;
            m_evt   = ne;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Advance one edge, then compare every output with the model away from the edge.
    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cyc++;
        chk("btn",   32'(bus.buttons_o), 32'(m_btn));
        chk("press", 32'(bus.press_o),   32'(m_press));
        chk("rel",   32'(bus.release_o), 32'(m_rel));
        chk("evt",   32'(bus.event_o),   32'(m_evt));
        chk("irq",   32'(bus.irq_o),     32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.buttons_i   = '0;
        bus.event_clr_i = '0;
        wb_rst_i        = 1'b1;
        ticks(2);
        chk("rst_btn", 32'(bus.buttons_o), 32'h0);
        chk("rst_evt", 32'(bus.event_o),   32'h0);
        chk("rst_irq", 32'(bus.irq_o),     32'h0);
        wb_rst_i = 1'b0;

        // First press on channel 0: accepted at edge 6, irq one edge later.
        bus.buttons_i = 3'b001;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) chk("p1_btn_e5", 32'(bus.buttons_o), 32'h0);
            if (e == 6) begin
                chk("p1_btn_e6",   32'(bus.buttons_o), 32'h1);
                chk("p1_press_e6", 32'(bus.press_o),   32'h1);
                chk("p1_evt_e6",   32'(bus.event_o),   32'h1);
                chk("p1_irq_e6",   32'(bus.irq_o),     32'h0);
            end
            if (e == 7) begin
                chk("p1_press_e7", 32'(bus.press_o), 32'h0);
                chk("p1_irq_e7",   32'(bus.irq_o),   32'h1);
            end
        end

        // Channel 1 bounces every 2 cycles: must never get through.
        for (int c = 0; c < 20; c++) begin
            bus.buttons_i = {1'b0, 1'(c >> 1), 1'b1};
            tick();
            chk("bounce_btn1", 32'(bus.buttons_o[1] | bus.press_o[1] | bus.event_o[1]), 32'h0);
        end
        bus.buttons_i = 3'b001;
        ticks(8);

        // Clearing the flag, then irq follows one edge later.
        bus.event_clr_i = 3'b001;
        tick();
        bus.event_clr_i = '0;
        chk("clr_evt", 32'(bus.event_o), 32'h0);
        chk("clr_irq_lag", 32'(bus.irq_o), 32'h1);
        tick();
        chk("clr_irq", 32'(bus.irq_o), 32'h0);

        // Clear asserted in the press_o cycle of a new press: set wins.
        bus.buttons_i = 3'b000;
        ticks(8);
        bus.buttons_i = 3'b001;
        ticks(6);
        chk("sw_press", 32'(bus.press_o), 32'h1);
        bus.event_clr_i = 3'b001;
        tick();
        bus.event_clr_i = '0;
        chk("sw_evt", 32'(bus.event_o[0]), 32'h1);
        ticks(2);

        // All channels together.
        bus.event_clr_i = 3'b111;
        tick();
        bus.event_clr_i = '0;
        bus.buttons_i = 3'b000;
        ticks(8);
        bus.buttons_i = 3'b111;
        ticks(6);
        chk("all_btn",   32'(bus.buttons_o), 32'h7);
        chk("all_press", 32'(bus.press_o),   32'h7);
        tick();
        chk("all_press_1cyc", 32'(bus.press_o), 32'h0);
        chk("all_evt", 32'(bus.event_o), 32'h7);
        bus.event_clr_i = 3'b111;
        tick();
        bus.event_clr_i = '0;
        bus.buttons_i = 3'b000;
        ticks(6);
        chk("all_rel", 32'(bus.release_o), 32'h7);
        tick();
`ifdef BUTTON_DEBOUNCE_RELEASE_EVENT_EN
        chk("all_rel_evt", 32'(bus.event_o), 32'h7);
`else
        chk("all_rel_evt", 32'(bus.event_o), 32'h0);
`endif
        ticks(8);

        // Reset while channel 2 is mid-count with raw held high.
        bus.buttons_i = 3'b100;
        ticks(4);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        chk("mid_rst_out", 32'({bus.buttons_o, bus.press_o, bus.release_o, bus.event_o, bus.irq_o}), 32'h0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) chk("mid_rst_btn_e5", 32'(bus.buttons_o[2]), 32'h0);
            if (e == 6) begin
                chk("mid_rst_btn_e6",   32'(bus.buttons_o[2]), 32'h1);
                chk("mid_rst_press_e6", 32'(bus.press_o[2]),   32'h1);
            end
        end

        // Short holds: 3 cycles rejected, exactly 5 accepted.
        bus.buttons_i = 3'b000;
        ticks(8);
        bus.buttons_i = 3'b001;
        ticks(3);
        bus.buttons_i = 3'b000;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk("hold3_btn0", 32'(bus.buttons_o[0]), 32'h0);
        end
        bus.buttons_i = 3'b001;
        ticks(5);
        bus.buttons_i = 3'b000;
        for (int e = 6; e <= 11; e++) begin
            tick();
            if (e == 6)  chk("hold5_rise", 32'(bus.buttons_o[0]), 32'h1);
            if (e == 10) chk("hold5_still", 32'(bus.buttons_o[0]), 32'h1);
            if (e == 11) chk("hold5_fall", 32'(bus.buttons_o[0]), 32'h0);
        end

        // Random traffic, clears and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.buttons_i = NB'($urandom);
            bus.event_clr_i = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
            wb_rst_i = ($urandom_range(0, 399) == 0);
            tick();
        end
        wb_rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-conditioning stage directly upstream of the Wishbone buttons/LEDs peripheral in the user project area.
- Takes the raw, asynchronous button pads (mprj_io[9:7]) and synchronizes and debounces each one.
- Drives clean levels, one-cycle press/release pulses and sticky event flags into the peripheral; the peripheral exposes these to firmware and drives the LEDs.
- All logic is in the Wishbone clock domain.

Parameters:
- NUM_BUTTONS, 3, number of independent button channels.
- CNT_WIDTH, 16, width of each per-channel debounce counter.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new level. Legal range 1 to 2^CNT_WIDTH-1.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- buttons_i  input  NUM_BUTTONS  raw asynchronous button pads.
- event_clr_i  input  NUM_BUTTONS  write-1-to-clear strobe for event_o, one bit per channel.
- buttons_o  output  NUM_BUTTONS  debounced button level.
- press_o  output  NUM_BUTTONS  one-cycle pulse on each debounced 0->1 transition.
- release_o  output  NUM_BUTTONS  one-cycle pulse on each debounced 1->0 transition.
- event_o  output  NUM_BUTTONS  sticky event flags.
- irq_o  output  1  OR-reduction of event_o, registered.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: all of the following are 0 — sync flops, counters, buttons_o, press_o, release_o, event_o, irq_o.
- Synchronizer: two-flop synchronizer per channel. sync2 is the synchronized value.
- Per-channel counter, evaluated each rising edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Bounce handling: any return of sync2 to the stable value before acceptance resets cnt to 0. Glitches shorter than DEBOUNCE_CYCLES cycles never reach buttons_o.
- Latency: number the edge that first samples a new raw level as edge 1. buttons_o changes at edge DEBOUNCE_CYCLES+2, provided raw has been held. With DEBOUNCE_CYCLES=1 this is edge 3.
- Pulses: press_o and release_o are registered and assert in the same cycle buttons_o changes. They are high for exactly one cycle and never both high on the same channel.
- event_o:
  - Set by press_o.
  - Cleared by event_clr_i at the next edge.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clearing an already-zero flag has no effect.
- irq_o: equals the registered |event_o, so it lags event_o by one cycle.
- Channel independence: channels are fully independent. Simultaneous transitions on multiple channels each produce their own pulses in the same cycle.
- Reset mid-count: all counts abort and buttons_o returns to 0. If the raw input is still high after reset, a fresh press is detected after the full latency.
- Counter width: the counter never wraps, because the terminal compare occurs at DEBOUNCE_CYCLES-1 < 2^CNT_WIDTH.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_RELEASE_EVENT_EN.
- Defined: event_o is set by press_o OR release_o. Set-wins priority over event_clr_i still applies.
- Undefined: event_o is set only by press_o; release_o still pulses.
- Ports and timing are identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then buttons_i=3'b001 held, first sampled at edge 1 -> buttons_o=3'b001 from edge 6. press_o[0]=1 for exactly edge 6 only. event_o[0]=1 from edge 6. irq_o=1 from edge 7.
- buttons_i[1] toggles every 2 cycles for 20 cycles, then returns to 0 -> buttons_o[1], press_o[1], release_o[1], event_o[1] stay 0 throughout.
- event_o=3'b001, pulse event_clr_i=3'b001 for one cycle -> event_o=0 next edge, irq_o=0 one edge later. Repeat with event_clr_i asserted in the press_o cycle of a new press -> event_o[0] stays 1.
- buttons_i=3'b111 simultaneously -> buttons_o=3'b111 and press_o=3'b111 in the same single cycle. Release all -> release_o=3'b111 one cycle. event_o is unchanged without the macro, or remains 3'b111 with BUTTON_DEBOUNCE_RELEASE_EVENT_EN.
- Assert wb_rst_i for 1 cycle while channel 2 cnt=2 and raw held high -> all outputs 0 after the reset edge. buttons_o[2] rises 6 edges after reset deasserts, with a new press_o pulse.
- Hold buttons_i[0]=1 for 3 cycles, then 0 -> no output change. Hold for exactly 5 cycles -> buttons_o[0] rises, then falls after the release latency.
